// File: rtl/bip_alu_seq_if.sv
// Handshake and result bus between the BIP control unit and the sequential ALU.
interface bip_alu_seq_if #(
  parameter int unsigned WIDTH = 12
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] acc;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             overflow;

  // Control unit side: issues ops and observes results.
  modport master (
    output start, op, operand,
    input  ready, done, acc, zero, neg, carry, overflow
  );

  // ALU side.
  modport slave (
    input  start, op, operand,
    output ready, done, acc, zero, neg, carry, overflow
  );
endinterface

// File: rtl/bip_alu_seq.sv
// Accumulator-based ALU for the BIP datapath: single-cycle logic/arith ops and a
// WIDTH-iteration shift-add multiply behind a start/ready/done handshake.
module bip_alu_seq #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CNT_W = 5
) (
  input logic          clk,
  input logic          reset,
  bip_alu_seq_if.slave bus
);

  typedef enum logic [2:0] {
    OpLoad = 3'b000,
    OpAdd  = 3'b001,
    OpSub  = 3'b010,
    OpAnd  = 3'b011,
    OpOr   = 3'b100,
    OpXor  = 3'b101,
    OpMul  = 3'b110,
    OpClr  = 3'b111
  } op_e;

  typedef enum logic {
    StIdle,
    StMul
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   acc_q;
  logic               zero_q;
  logic               neg_q;
  logic               carry_q;
  logic               ovf_q;
  logic               done_q;
  logic               ready_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;

  op_e                op;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [2*WIDTH-1:0] prod_next;

  assign op = op_e'(bus.op);

  // Single-cycle result and flags for the op presented on the bus.
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, bus.operand};
    diff    = {1'b0, acc_q} - {1'b0, bus.operand};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op)
      OpLoad: alu_res = bus.operand;
      OpAdd: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (acc_q[WIDTH-1] == bus.operand[WIDTH-1]) &&
                  (sum[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OpSub: begin
        alu_res = diff[WIDTH-1:0];
        // Top bit of the extended difference is the unsigned borrow.
        alu_c   = diff[WIDTH];
        alu_v   = (acc_q[WIDTH-1] != bus.operand[WIDTH-1]) &&
                  (diff[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OpAnd:   alu_res = acc_q & bus.operand;
      OpOr:    alu_res = acc_q | bus.operand;
      OpXor:   alu_res = acc_q ^ bus.operand;
      OpMul:   alu_res = acc_q;
      OpClr:   alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  // Partial product after the current shift-add iteration.
  always_comb begin
    prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Control FSM, accumulator, flags and multiply datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start && ready_q) begin
            if (op == OpMul) begin
              mcand_q  <= {{WIDTH{1'b0}}, acc_q};
              mplier_q <= bus.operand;
              prod_q   <= '0;
              cnt_q    <= '0;
              ready_q  <= 1'b0;
              state_q  <= StMul;
            end else begin
              acc_q   <= alu_res;
              zero_q  <= (alu_res == '0);
              neg_q   <= alu_res[WIDTH-1];
              carry_q <= alu_c;
              ovf_q   <= alu_v;
              done_q  <= 1'b1;
            end
          end
        end
        StMul: begin
          prod_q   <= prod_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            acc_q   <= prod_next[WIDTH-1:0];
            zero_q  <= (prod_next[WIDTH-1:0] == '0);
            neg_q   <= prod_next[WIDTH-1];
            carry_q <= 1'b0;
            // Any bits above the accumulator width are lost.
            ovf_q   <= |prod_next[2*WIDTH-1:WIDTH];
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.acc      = acc_q;
  assign bus.zero     = zero_q;
  assign bus.neg      = neg_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;
  assign bus.done     = done_q;
  assign bus.ready    = ready_q;

endmodule

// File: tb/tb_bip_alu_seq.sv
// Directed self-checking bench for bip_alu_seq at WIDTH=12.
module tb_bip_alu_seq;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  bip_alu_seq_if #(.WIDTH(12)) bus ();

  bip_alu_seq #(
    .WIDTH(12),
    .CNT_W(5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [11:0] a, input logic z,
                           input logic n, input logic c, input logic v,
                           input logic d, input logic r);
    check({tag, ".acc"}, {20'd0, bus.acc}, {20'd0, a});
    check({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, z});
    check({tag, ".neg"}, {31'd0, bus.neg}, {31'd0, n});
    check({tag, ".carry"}, {31'd0, bus.carry}, {31'd0, c});
    check({tag, ".ovf"}, {31'd0, bus.overflow}, {31'd0, v});
    check({tag, ".done"}, {31'd0, bus.done}, {31'd0, d});
    check({tag, ".ready"}, {31'd0, bus.ready}, {31'd0, r});
  endtask

  // Present one op for exactly one rising edge; returns at the following falling edge.
  task automatic issue(input logic [2:0] o, input logic [11:0] v);
    bus.start   = 1'b1;
    bus.op      = o;
    bus.operand = v;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = OP_LOAD;
    bus.operand = '0;
    repeat (3) @(negedge clk);
    check_all("reset", 12'h000, 1, 0, 0, 0, 0, 1);
    reset = 1'b0;
    @(negedge clk);
    check_all("idle", 12'h000, 1, 0, 0, 0, 0, 1);

    // Back-to-back single-cycle ops, signed overflow on ADD.
    issue(OP_LOAD, 12'h7FF);
    check_all("load7ff", 12'h7FF, 0, 0, 0, 0, 1, 1);
    issue(OP_ADD, 12'h001);
    check_all("add1", 12'h800, 0, 1, 0, 1, 1, 1);
    @(negedge clk);
    check("add1.done_drop", {31'd0, bus.done}, 32'd0);

    // SUB with borrow, then ADD wrapping to zero.
    issue(OP_LOAD, 12'h005);
    issue(OP_SUB, 12'h007);
    check_all("sub7", 12'hFFE, 0, 1, 1, 0, 1, 1);
    issue(OP_ADD, 12'h002);
    check_all("add_wrap", 12'h000, 1, 0, 1, 0, 1, 1);

    // MUL 0x010 * 0x020: ready low for 12 cycles, acc held.
    issue(OP_LOAD, 12'h010);
    issue(OP_MUL, 12'h020);
    check_all("mul1.k", 12'h010, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 12; i++) begin
      @(negedge clk);
      check("mul1.busy_ready", {31'd0, bus.ready}, 32'd0);
      check("mul1.busy_done", {31'd0, bus.done}, 32'd0);
      check("mul1.busy_acc", {20'd0, bus.acc}, 32'h010);
    end
    @(negedge clk);
    check_all("mul1.end", 12'h200, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    check("mul1.done_drop", {31'd0, bus.done}, 32'd0);

    // MUL truncation to zero, with an ignored ADD during the busy window.
    issue(OP_LOAD, 12'h100);
    issue(OP_MUL, 12'h100);
    repeat (2) @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = OP_ADD;
    bus.operand = 12'h123;
    @(negedge clk);
    bus.start = 1'b0;
    check_all("mul2.ignored", 12'h100, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mul2.busy_done", {31'd0, bus.done}, 32'd0);
      check("mul2.busy_acc", {20'd0, bus.acc}, 32'h100);
    end
    @(negedge clk);
    check_all("mul2.end", 12'h000, 1, 0, 0, 1, 1, 1);
    @(negedge clk);
    check_all("mul2.after", 12'h000, 1, 0, 0, 1, 0, 1);

    // Reset at iteration 5 aborts the multiply.
    issue(OP_LOAD, 12'h003);
    issue(OP_MUL, 12'h005);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all("mul_abort", 12'h000, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("mul_abort.no_done", {31'd0, bus.done}, 32'd0);
    end
    issue(OP_LOAD, 12'hABC);
    check_all("loadabc", 12'hABC, 0, 1, 0, 0, 1, 1);

    // Set carry and overflow so the logic ops must clear them.
    issue(OP_ADD, 12'h800);
    check_all("add800", 12'h2BC, 0, 0, 1, 1, 1, 1);
    issue(OP_LOAD, 12'hF0F);
    check_all("loadf0f", 12'hF0F, 0, 1, 0, 0, 1, 1);
    issue(OP_AND, 12'h0FF);
    check_all("and", 12'h00F, 0, 0, 0, 0, 1, 1);
    issue(OP_OR, 12'h800);
    check_all("or", 12'h80F, 0, 1, 0, 0, 1, 1);
    issue(OP_XOR, 12'h80F);
    check_all("xor", 12'h000, 1, 0, 0, 0, 1, 1);
    issue(OP_LOAD, 12'h123);
    issue(OP_CLR, 12'h456);
    check_all("clr", 12'h000, 1, 0, 0, 0, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bip_alu_seq.md
Name: bip_alu_seq

Overview:
- Parametrised, accumulator-based arithmetic unit for the BIP datapath. Next generation of the existing combinational add/sub unit.
- Holds a registered accumulator (ACC) and registered status flags.
- Supports single-cycle LOAD/ADD/SUB/AND/OR/XOR/CLR and a multi-cycle shift-add multiply.
- Uses a start/ready/done handshake so the control unit can stall on long operations.

Parameters:
- WIDTH, 12, datapath width in bits (ACC, operand). Legal range 4..32.
- CNT_W, 5, width of the multiply iteration counter. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to execute op; accepted only when ready=1.
- op  in  3  operation code, sampled with start.
- operand  in  WIDTH  B operand, sampled with start.
- ready  out  1  unit can accept a new op this cycle.
- done  out  1  one-cycle pulse: result and flags of the last accepted op are valid.
- acc  out  WIDTH  accumulator value (registered).
- zero  out  1  acc == 0 (registered with acc).
- neg  out  1  acc[WIDTH-1] (registered with acc).
- carry  out  1  ADD carry-out / SUB borrow.
- overflow  out  1  signed overflow (ADD/SUB) or MUL truncation.

Behaviour:
- Reset (synchronous): acc=0, zero=1, neg=0, carry=0, overflow=0, done=0, ready=1, state=IDLE, multiply counter and temporaries cleared. A reset asserted mid-multiply aborts it; no done pulse follows.
- Op codes:
  - 000 LOAD: acc=operand.
  - 001 ADD: acc=acc+operand.
  - 010 SUB: acc=acc-operand.
  - 011 AND.
  - 100 OR.
  - 101 XOR.
  - 110 MUL: acc=low WIDTH bits of unsigned acc*operand.
  - 111 CLR: acc=0.
- Accept condition: start=1 and ready=1 at a rising edge (edge k). start while ready=0 is ignored and not queued.
- State machine: IDLE and MUL.
- IDLE, single-cycle op accepted at edge k:
  - acc and flags updated at edge k.
  - done=1 for the cycle after edge k.
  - ready stays 1, so back-to-back ops are accepted every cycle.
- IDLE, MUL accepted at edge k:
  - Multiplicand (acc), multiplier (operand) and a 2*WIDTH partial product are latched.
  - ready=0 from the cycle after edge k.
  - Move to MUL with counter=0.
- MUL state:
  - One shift-add iteration per edge, k+1 .. k+WIDTH.
  - At edge k+WIDTH: acc = product[WIDTH-1:0], flags updated, state=IDLE, ready=1, done=1 for exactly one cycle.
  - acc holds its old value during iterations.
  - MUL latency = WIDTH+1 edges from accept to done.
- Flags (all updated only at the edge that writes acc; otherwise held):
  - zero = new acc == 0; neg = new acc MSB.
  - ADD: carry = bit WIDTH of the (WIDTH+1)-bit unsigned sum; overflow = operands same sign and result sign differs.
  - SUB: carry = 1 when operand > acc (unsigned borrow); overflow = operands differ in sign and result sign differs from acc.
  - LOAD/AND/OR/XOR/CLR: carry=0, overflow=0.
  - MUL: carry=0, overflow = (product[2*WIDTH-1:WIDTH] != 0).
- Wrap-around: ADD/SUB results are modulo 2^WIDTH; no saturation.
- done is never asserted without a matching accepted op. done and ready are both 1 in the cycle after a completing op.

Test Plan (WIDTH=12):
- Reset, then LOAD 0x7FF, then ADD 0x001 on the next cycle -> acc=0x800, neg=1, overflow=1, carry=0, zero=0; done high one cycle after each accept; ready never drops.
- LOAD 0x005, SUB 0x007 -> acc=0xFFE, carry=1, neg=1, overflow=0. Then ADD 0x002 -> acc=0x000, zero=1, carry=1.
- LOAD 0x010, MUL 0x020 -> ready low for 12 cycles, acc holds 0x010 throughout, then acc=0x200 with done=1 and ready=1 in the same cycle, overflow=0.
- LOAD 0x100, MUL 0x100 -> acc=0x000, zero=1, overflow=1. A start with op=ADD pulsed during the busy window is ignored (acc unchanged, no extra done).
- Start MUL, assert reset at iteration 5 -> next cycle acc=0, zero=1, ready=1, done=0; no done pulse afterwards. A following LOAD 0xABC works normally.
- Logic ops: LOAD 0xF0F, AND 0x0FF -> 0x00F; OR 0x800 -> 0x80F (neg=1); XOR 0x80F -> 0x000 (zero=1); carry and overflow are 0 after each.
